// File: rtl/m92_color_mixer_if.sv
// m92_color_mixer_if: pixel, CPU-register and palette-chip signals of the colour mixer.
//   master : drives CE_PIX, blanks, layer pixels and CPU writes; receives CA/CB/SELECT/CBLK.
//   slave  : the mixer side.
//   M92_MIXER_LAYER_DEBUG_EN adds DBG_MASK[2:0] ({A, B, sprite}, 1 = force transparent).
interface m92_color_mixer_if;
    logic       CE_PIX;
    logic       HBLANK;
    logic       VBLANK;
    logic [7:0] TA_COLOR;
    logic       TA_PRIO;
    logic [7:0] TB_COLOR;
    logic [7:0] SP_COLOR;
    logic       CPU_WR;
    logic       CPU_A;
    logic [7:0] CPU_DIN;
    logic [7:0] CA;
    logic [7:0] CB;
    logic       SELECT;
    logic       CBLK;
`ifdef M92_MIXER_LAYER_DEBUG_EN
    logic [2:0] DBG_MASK;
    modport master (
        output CE_PIX, HBLANK, VBLANK, TA_COLOR, TA_PRIO, TB_COLOR, SP_COLOR,
        output CPU_WR, CPU_A, CPU_DIN, DBG_MASK,
        input  CA, CB, SELECT, CBLK
    );
    modport slave (
        input  CE_PIX, HBLANK, VBLANK, TA_COLOR, TA_PRIO, TB_COLOR, SP_COLOR,
        input  CPU_WR, CPU_A, CPU_DIN, DBG_MASK,
        output CA, CB, SELECT, CBLK
    );
`else
    modport master (
        output CE_PIX, HBLANK, VBLANK, TA_COLOR, TA_PRIO, TB_COLOR, SP_COLOR,
        output CPU_WR, CPU_A, CPU_DIN,
        input  CA, CB, SELECT, CBLK
    );
    modport slave (
        input  CE_PIX, HBLANK, VBLANK, TA_COLOR, TA_PRIO, TB_COLOR, SP_COLOR,
        input  CPU_WR, CPU_A, CPU_DIN,
        output CA, CB, SELECT, CBLK
    );
`endif
endinterface

// File: rtl/m92_color_mixer.sv
// m92_color_mixer: per-pixel tile/sprite priority mixer feeding the palette chip.
//   CLK_32M : system clock
//   RESET   : synchronous, active-high reset
//   bus     : m92_color_mixer_if.slave
//             in  : CE_PIX, HBLANK, VBLANK, TA_COLOR, TA_PRIO, TB_COLOR, SP_COLOR,
//                   CPU_WR, CPU_A (0 = backdrop, 1 = control), CPU_DIN
//             out : CA (tile side), CB (sprite side), SELECT (1 = CA), CBLK (blank)
//   PIPE_DEPTH : CE_PIX stages from input sample to output, 2..4
//   Optional macro M92_MIXER_LAYER_DEBUG_EN adds DBG_MASK[2:0] ({A, B, sprite}).
module m92_color_mixer #(
    parameter int PIPE_DEPTH = 2
) (
    input logic              CLK_32M,
    input logic              RESET,
    m92_color_mixer_if.slave bus
);
    // Stage word layout: {CA[7:0], CB[7:0], SELECT, CBLK}
    localparam logic [17:0] RESET_OUT = 18'h00001;
    localparam logic [17:0] BLANK_OUT = 18'h00003;

    if (PIPE_DEPTH < 2 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("m92_color_mixer: PIPE_DEPTH must be within 2..4");
    end

    logic [7:0] backdrop;
    logic [7:0] control;
    logic       reserved_unused;

    // Register writes ignore CE_PIX; stage 2 reads these registers, so a write
    // landing with a stage-2 update only affects the following pixel.
    always_ff @(posedge CLK_32M) begin
        if (RESET) begin
            backdrop <= 8'h00;
            control  <= 8'h07;
        end else if (bus.CPU_WR) begin
            if (bus.CPU_A)
                control <= bus.CPU_DIN;
            else
                backdrop <= bus.CPU_DIN;
        end
    end

    // control[7:4] is stored as written but has no function.
    assign reserved_unused = ^control[7:4];

    logic [7:0] s1_ta;
    logic [7:0] s1_tb;
    logic [7:0] s1_sp;
    logic       s1_prio;
    logic       s1_blank;
`ifdef M92_MIXER_LAYER_DEBUG_EN
    logic [2:0] s1_mask;
`endif

    always_ff @(posedge CLK_32M) begin
        if (RESET) begin
            s1_ta    <= 8'h00;
            s1_tb    <= 8'h00;
            s1_sp    <= 8'h00;
            s1_prio  <= 1'b0;
            s1_blank <= 1'b1;
`ifdef M92_MIXER_LAYER_DEBUG_EN
            s1_mask  <= 3'b000;
`endif
        end else if (bus.CE_PIX) begin
            s1_ta    <= bus.TA_COLOR;
            s1_tb    <= bus.TB_COLOR;
            s1_sp    <= bus.SP_COLOR;
            s1_prio  <= bus.TA_PRIO;
            s1_blank <= bus.HBLANK | bus.VBLANK;
`ifdef M92_MIXER_LAYER_DEBUG_EN
            s1_mask  <= bus.DBG_MASK;
`endif
        end
    end

    // Layer enables in control-register order: [0] A, [1] B, [2] sprite.
    logic [2:0] en;
`ifdef M92_MIXER_LAYER_DEBUG_EN
    assign en = control[2:0] & ~{s1_mask[0], s1_mask[1], s1_mask[2]};
`else
    assign en = control[2:0];
`endif

    logic        a_op;
    logic        b_op;
    logic        s_op;
    logic        a_hi;
    logic [7:0]  tile;
    logic [17:0] resolved;

    // CA always carries the best tile candidate, so when the sprite wins the
    // palette chip still sees what lies beneath it on the tile side.
    always_comb begin
        a_op     = en[0] && s1_ta[3:0] != 4'h0;
        b_op     = en[1] && s1_tb[3:0] != 4'h0;
        s_op     = en[2] && s1_sp[3:0] != 4'h0;
        a_hi     = a_op && s1_prio && !control[3];
        tile     = a_op ? s1_ta : b_op ? s1_tb : backdrop;
        resolved = s1_blank ? BLANK_OUT : {tile, s1_sp, a_hi || !s_op, 1'b0};
    end

    // st[2] is the resolved pixel; later entries are plain delay stages.
    // Reset leaves SELECT low but CBLK high; any carried blank re-forces the
    // blank word as it moves so all stages present the same blanked output.
    logic [17:0] st [2:PIPE_DEPTH];

    always_ff @(posedge CLK_32M) begin
        if (RESET) begin
            for (int i = 2; i <= PIPE_DEPTH; i++)
                st[i] <= RESET_OUT;
        end else if (bus.CE_PIX) begin
            st[2] <= resolved;
            for (int i = 3; i <= PIPE_DEPTH; i++)
                st[i] <= st[i-1][0] ? BLANK_OUT : st[i-1];
        end
    end

    assign bus.CA     = st[PIPE_DEPTH][17:10];
    assign bus.CB     = st[PIPE_DEPTH][9:2];
    assign bus.SELECT = st[PIPE_DEPTH][1];
    assign bus.CBLK   = st[PIPE_DEPTH][0];
endmodule

// File: tb/tb_m92_color_mixer.sv
// tb_m92_color_mixer: scoreboard bench driving a depth-2 and a depth-4 mixer in parallel.
module tb_m92_color_mixer;
    typedef struct packed {
        logic [7:0] id;
        logic [7:0] ca;
        logic [7:0] cb;
        logic       sel;
        logic       blk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       hb = 1'b0;
    logic       vb = 1'b0;
    logic [7:0] ta = 8'h00;
    logic       prio = 1'b0;
    logic [7:0] tb = 8'h00;
    logic [7:0] sp = 8'h00;
    logic       wr = 1'b0;
    logic       adr = 1'b0;
    logic [7:0] din = 8'h00;
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [7:0] id, logic [7:0] ca, logic [7:0] cb, logic sel, logic blk);
        exp_t e;
        e.id = id;
        e.ca = ca;
        e.cb = cb;
        e.sel = sel;
        e.blk = blk;
        return e;
    endfunction

    task automatic chk(int d, exp_t e, logic [17:0] got);
        checks++;
        if (got == {e.ca, e.cb, e.sel, e.blk})
            passed++;
        else
            $display("FAIL depth%0d px%0d got ca=%h cb=%h sel=%b blk=%b want ca=%h cb=%h sel=%b blk=%b",
                     d, e.id, got[17:10], got[9:2], got[1], got[0], e.ca, e.cb, e.sel, e.blk);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D = g ? 4 : 2;
        m92_color_mixer_if bus ();
        assign bus.CE_PIX   = ce;
        assign bus.HBLANK   = hb;
        assign bus.VBLANK   = vb;
        assign bus.TA_COLOR = ta;
        assign bus.TA_PRIO  = prio;
        assign bus.TB_COLOR = tb;
        assign bus.SP_COLOR = sp;
        assign bus.CPU_WR   = wr;
        assign bus.CPU_A    = adr;
        assign bus.CPU_DIN  = din;
`ifdef M92_MIXER_LAYER_DEBUG_EN
        assign bus.DBG_MASK = 3'b000;
`endif
        m92_color_mixer #(.PIPE_DEPTH(D)) dut (
            .CLK_32M(clk),
            .RESET  (rst),
            .bus    (bus)
        );
        exp_t q[$];
        exp_t last;
        // Reset forces the reset word; each CE_PIX pulse retires one queued
        // pixel; every other clock the output must hold the last one.
        initial begin
            bit r;
            bit c;
            last = mk(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
            forever begin
                @(posedge clk);
                r = rst;
                c = ce;
                #1;
                if (r)
                    last = mk(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
                else if (c) begin
                    if (q.size() == 0) begin
                        checks++;
                        $display("FAIL depth%0d queue underflow got empty want entry", D);
                    end else
                        last = q.pop_front();
                end
                chk(D, last, {bus.CA, bus.CB, bus.SELECT, bus.CBLK});
            end
        end
    end

    task automatic push(exp_t e);
        lane[0].q.push_back(e);
        lane[1].q.push_back(e);
    endtask

    // Reset with CE_PIX high; cleared stages then emit depth-1 blank pixels.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ce = 1'b1;
        lane[0].q.delete();
        lane[1].q.delete();
        lane[0].q.push_back(mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
        repeat (3) lane[1].q.push_back(mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b1));
        @(negedge clk);
        rst = 1'b0;
        ce = 1'b0;
    endtask

    task automatic pix(logic [7:0] id, logic [7:0] a, logic p, logic [7:0] b, logic [7:0] s,
                       logic [1:0] bl, logic [7:0] eca, logic [7:0] ecb, logic esel);
        @(negedge clk);
        ta = a;
        prio = p;
        tb = b;
        sp = s;
        hb = bl[0];
        vb = bl[1];
        ce = 1'b1;
        push(|bl ? mk(id, 8'h00, 8'h00, 1'b1, 1'b1) : mk(id, eca, ecb, esel, 1'b0));
        @(negedge clk);
        ce = 1'b0;
    endtask

    // A blanked pixel sits in stage 1 during the write so no checked pixel
    // straddles the register change.
    task automatic cpu_write(logic [7:0] id, logic a, logic [7:0] d);
        pix(id, 8'h31, 1'b0, 8'h52, 8'h74, 2'b10, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        wr = 1'b1;
        adr = a;
        din = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        repeat (2) @(negedge clk);
        pix(1,  8'h31, 1'b0, 8'h52, 8'h74, 2'b00, 8'h31, 8'h74, 1'b0);
        pix(2,  8'h31, 1'b1, 8'h52, 8'h74, 2'b00, 8'h31, 8'h74, 1'b1);
        pix(3,  8'h30, 1'b1, 8'h52, 8'h74, 2'b00, 8'h52, 8'h74, 1'b0);
        pix(4,  8'h30, 1'b0, 8'h50, 8'h74, 2'b00, 8'h00, 8'h74, 1'b0);
        pix(5,  8'h30, 1'b0, 8'h52, 8'h70, 2'b00, 8'h52, 8'h70, 1'b1);
        pix(6,  8'h31, 1'b0, 8'h52, 8'h74, 2'b01, 8'h00, 8'h00, 1'b1);
        pix(7,  8'h31, 1'b0, 8'h52, 8'h74, 2'b00, 8'h31, 8'h74, 1'b0);
        cpu_write(8, 1'b1, 8'h0F);
        pix(9,  8'h31, 1'b1, 8'h52, 8'h74, 2'b00, 8'h31, 8'h74, 1'b0);
        cpu_write(10, 1'b1, 8'h0E);
        pix(11, 8'h31, 1'b0, 8'h52, 8'h70, 2'b00, 8'h52, 8'h70, 1'b1);
        cpu_write(12, 1'b1, 8'h0D);
        pix(13, 8'h30, 1'b0, 8'h52, 8'h70, 2'b00, 8'h00, 8'h70, 1'b1);
        cpu_write(14, 1'b1, 8'h07);
        cpu_write(15, 1'b0, 8'hE5);
        pix(16, 8'h30, 1'b0, 8'h50, 8'h70, 2'b00, 8'hE5, 8'h70, 1'b1);
        pix(17, 8'h31, 1'b1, 8'h52, 8'h74, 2'b00, 8'h31, 8'h74, 1'b1);
        pix(18, 8'h31, 1'b0, 8'h52, 8'h11, 2'b00, 8'h31, 8'h11, 1'b0);
        repeat (10) @(negedge clk);
        pix(19, 8'h30, 1'b0, 8'h52, 8'h70, 2'b00, 8'h52, 8'h70, 1'b1);
        do_reset();
        pix(20, 8'h30, 1'b0, 8'h50, 8'h70, 2'b00, 8'h00, 8'h70, 1'b1);
        pix(21, 8'h31, 1'b0, 8'h52, 8'h74, 2'b00, 8'h31, 8'h74, 1'b0);
        for (int i = 22; i < 26; i++)
            pix(8'(i), 8'h31, 1'b0, 8'h52, 8'h74, 2'b01, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (lane[0].q.size() == 1 && lane[1].q.size() == 3)
            passed++;
        else
            $display("FAIL residue got %0d/%0d want 1/3", lane[0].q.size(), lane[1].q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
